// File: rtl/clk_div_monitor.sv
// Receive-side period/duty monitor for a divided clock, with lock detection and a stall watchdog.
// Optional duty-cycle qualification is enabled by defining DIVMON_DUTY_CHECK_EN.
module clk_div_monitor #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned EXP_PERIOD = 5,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_CNT   = 4
) (
  input  logic             Clk,
  input  logic             rst_n,
  input  logic             clk_in,
  input  logic             clr_err,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err_sticky,
  output logic             stall
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_ONE;

  localparam int unsigned P_LO     = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;
  localparam int unsigned P_HI_RAW = EXP_PERIOD + TOL;
  localparam int unsigned P_HI     = (P_HI_RAW > (2**CNT_W) - 1) ? ((2**CNT_W) - 1) : P_HI_RAW;
  localparam logic [CNT_W:0] P_LO_W = P_LO[CNT_W:0];
  localparam logic [CNT_W:0] P_HI_W = P_HI[CNT_W:0];
  localparam logic [3:0]     LOCK_W = LOCK_CNT[3:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQ,
    S_LOCKED
  } state_e;

  state_e           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] period_q;
  logic [3:0]       gcnt_q, gcnt_inc;
  logic             meas_valid_q, locked_q, err_q, stall_q;
  logic             rise, period_ok, duty_ok, good, stall_hit;

  always_comb begin
    rise = s2_q & ~s3_q;

    pcnt_d = pcnt_q;
    if (rise) begin
      pcnt_d = CNT_ONE;
    end else if (pcnt_q != CNT_MAX) begin
      pcnt_d = pcnt_q + CNT_ONE;
    end

    period_ok = ({1'b0, pcnt_q} >= P_LO_W) && ({1'b0, pcnt_q} <= P_HI_W);
    good      = period_ok && duty_ok;
    // pcnt_q one below saturation with no rise means it saturates on this edge
    stall_hit = ~rise && (pcnt_q == CNT_PRE);
    gcnt_inc  = gcnt_q + 4'd1;
  end

`ifdef DIVMON_DUTY_CHECK_EN
  localparam int unsigned H_LO = EXP_PERIOD / 2;
  localparam int unsigned H_HI = (EXP_PERIOD + 1) / 2;
  localparam logic [CNT_W-1:0] H_LO_W = H_LO[CNT_W-1:0];
  localparam logic [CNT_W-1:0] H_HI_W = H_HI[CNT_W-1:0];

  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_q;

  always_comb begin
    hcnt_d = hcnt_q;
    if (rise) begin
      hcnt_d = CNT_ONE;
    end else if (s2_q && (hcnt_q != CNT_MAX)) begin
      hcnt_d = hcnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      high_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      if (rise && (state_q != S_IDLE)) begin
        high_q <= hcnt_q;
      end
    end
  end

  assign duty_ok   = (hcnt_q >= H_LO_W) && (hcnt_q <= H_HI_W);
  assign high_time = high_q;
`else
  assign duty_ok   = 1'b1;
  assign high_time = '0;
`endif

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      pcnt_q       <= '0;
      period_q     <= '0;
      gcnt_q       <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      s1_q         <= clk_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      pcnt_q       <= pcnt_d;
      meas_valid_q <= 1'b0;

      // Clear first so an error set further down on the same edge takes priority
      if (clr_err) begin
        err_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (rise) begin
            state_q <= S_ACQ;
            gcnt_q  <= '0;
            stall_q <= 1'b0;
          end
        end
        S_ACQ, S_LOCKED: begin
          if (rise) begin
            period_q     <= pcnt_q;
            meas_valid_q <= 1'b1;
            if (good) begin
              if (state_q == S_ACQ) begin
                gcnt_q <= gcnt_inc;
                if (gcnt_inc == LOCK_W) begin
                  state_q  <= S_LOCKED;
                  locked_q <= 1'b1;
                end
              end
            end else begin
              state_q  <= S_ACQ;
              gcnt_q   <= '0;
              locked_q <= 1'b0;
              err_q    <= 1'b1;
            end
          end else if (stall_hit) begin
            state_q  <= S_IDLE;
            gcnt_q   <= '0;
            stall_q  <= 1'b1;
            locked_q <= 1'b0;
            err_q    <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign period     = period_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign err_sticky = err_q;
  assign stall      = stall_q;

endmodule
